// File: rtl/pe_credit_traffic_gen.sv
// pe_credit_traffic_gen: credit-flow traffic generator and receive checker for one router port.
//
// Transmit side injects flits {dest, src=NODE_ID, seq} while it holds a downstream credit.
// It keeps at most CREDITS flits outstanding, and each ci_i pulse returns one credit.
// Receive side accepts every in_valid_i flit and checks the dest field against NODE_ID.
// It also checks the seq field against a per-source expected-sequence table.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   start_i            1-cycle pulse: IDLE/DONE -> SEND
//   dest_mode_i        0 = fixed dest_cfg_i, 1 = round-robin over 0..NODES-1 skipping NODE_ID
//   dest_cfg_i         fixed destination
//   gap_cfg_i          idle cycles after each sent flit
//   pkt_limit_i        flits to send, 0 = unlimited
//   ci_i               credit return
//   dataout_o          flit to router, held between sends
//   out_valid_o        one cycle per flit
//   datain_i, in_valid_i  flit from router
//   tx_count_o, rx_count_o  saturating flit counters
//   busy_o, done_o     run status
//   credit_err_o       sticky: credit returned with nothing outstanding
//   rx_err_o           sticky: received flit with wrong dest or out-of-order seq
module pe_credit_traffic_gen #(
    parameter int DATA_W  = 20,
    parameter int ID_W    = 4,
    parameter int CREDITS = 4,
    parameter int NODE_ID = 0,
    parameter int NODES   = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              dest_mode_i,
    input  logic [ID_W-1:0]   dest_cfg_i,
    input  logic [CNT_W-1:0]  gap_cfg_i,
    input  logic [CNT_W-1:0]  pkt_limit_i,
    input  logic              ci_i,
    output logic [DATA_W-1:0] dataout_o,
    output logic              out_valid_o,
    input  logic [DATA_W-1:0] datain_i,
    input  logic              in_valid_i,
    output logic [CNT_W-1:0]  tx_count_o,
    output logic [CNT_W-1:0]  rx_count_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              credit_err_o,
    output logic              rx_err_o
);
    localparam int SEQ_W = DATA_W - 2 * ID_W;
    localparam int IDX_W = $clog2(NODES);
    localparam logic [ID_W-1:0]  MY_ID    = ID_W'(NODE_ID);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NODES - 1);
    localparam logic [ID_W-1:0]  RR_FIRST = (NODE_ID == 0) ? ID_W'(1) : '0;
    localparam logic [ID_W:0]    NODES_L  = (ID_W + 1)'(NODES);
    localparam logic [CNT_W-1:0] CRED_L   = CNT_W'(CREDITS);

    typedef enum logic [2:0] {IDLE, SEND, GAP, DRAIN, DONE} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   used_q, gap_q, tx_q, rx_q;
    logic [SEQ_W-1:0]   seq_q;
    logic [ID_W-1:0]    rr_q;
    logic [DATA_W-1:0]  dataout_q;
    logic               out_valid_q, credit_err_q, rx_err_q;
    logic [SEQ_W-1:0]   exp_q [NODES];

    logic               send, limit_hit;
    logic [CNT_W-1:0]   tx_d;
    logic [ID_W-1:0]    dest_d, rr_d;

    // Next round-robin target: step once, and step again if that lands on our own ID.
    function automatic logic [ID_W-1:0] rr_step(input logic [ID_W-1:0] p);
        return (p == LAST_ID) ? '0 : p + 1'b1;
    endfunction

    assign send      = (state_q == SEND) && (used_q < CRED_L);
    assign tx_d      = (&tx_q) ? tx_q : tx_q + 1'b1;
    // >= rather than == so a limit lowered mid-run still terminates the run.
    assign limit_hit = (pkt_limit_i != '0) && (tx_d >= pkt_limit_i);
    assign dest_d    = dest_mode_i ? rr_q : dest_cfg_i;
    assign rr_d      = (rr_step(rr_q) == MY_ID) ? rr_step(rr_step(rr_q)) : rr_step(rr_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            used_q       <= '0;
            gap_q        <= '0;
            tx_q         <= '0;
            seq_q        <= '0;
            rr_q         <= RR_FIRST;
            dataout_q    <= '0;
            out_valid_q  <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            out_valid_q <= send;
            if (send) begin
                dataout_q <= {dest_d, MY_ID, seq_q};
                seq_q     <= seq_q + 1'b1;
                rr_q      <= rr_d;
                tx_q      <= tx_d;
            end
            // A send and a credit return in the same cycle cancel out.
            if (send && !ci_i)
                used_q <= used_q + 1'b1;
            else if (!send && ci_i && used_q != '0)
                used_q <= used_q - 1'b1;
            if (!send && ci_i && used_q == '0)
                credit_err_q <= 1'b1;
            case (state_q)
                IDLE:  if (start_i) state_q <= SEND;
                SEND: begin
                    if (send) begin
                        state_q <= limit_hit ? DRAIN : (gap_cfg_i != '0) ? GAP : SEND;
                        // Loaded one short: the cycle leaving GAP is itself an idle cycle.
                        gap_q   <= gap_cfg_i - 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == '0)
                        state_q <= SEND;
                    else
                        gap_q <= gap_q - 1'b1;
                end
                DRAIN: if (used_q == '0) state_q <= DONE;
                DONE: begin
                    if (start_i) begin
                        state_q <= SEND;
                        tx_q    <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [ID_W-1:0]  rx_dst, rx_src;
    logic [SEQ_W-1:0] rx_seq, rx_exp;
    logic [IDX_W-1:0] rx_idx;
    logic             rx_src_ok, rx_bad;

    assign rx_dst    = datain_i[SEQ_W+ID_W +: ID_W];
    assign rx_src    = datain_i[SEQ_W +: ID_W];
    assign rx_seq    = datain_i[SEQ_W-1:0];
    assign rx_src_ok = {1'b0, rx_src} < NODES_L;
    assign rx_idx    = rx_src[IDX_W-1:0];
    assign rx_exp    = exp_q[rx_idx];
    assign rx_bad    = (rx_dst != MY_ID) || !rx_src_ok || (rx_seq != rx_exp);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_q     <= '0;
            rx_err_q <= 1'b0;
            for (int i = 0; i < NODES; i++) exp_q[i] <= '0;
        end else if (in_valid_i) begin
            rx_q <= (&rx_q) ? rx_q : rx_q + 1'b1;
            if (rx_src_ok) exp_q[rx_idx] <= rx_exp + 1'b1;
            if (rx_bad) rx_err_q <= 1'b1;
        end
    end

    assign dataout_o    = dataout_q;
    assign out_valid_o  = out_valid_q;
    assign tx_count_o   = tx_q;
    assign rx_count_o   = rx_q;
    assign busy_o       = (state_q == SEND) || (state_q == GAP) || (state_q == DRAIN);
    assign done_o       = (state_q == DONE);
    assign credit_err_o = credit_err_q;
    assign rx_err_o     = rx_err_q;
endmodule
